uart_tx_framer: RTL



---
 rtl/uart_pkg.sv | 18 +
 rtl/flex_pts_sr.sv | 28 ++
 rtl/uart_tx_framer.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit state encoding, line levels and default framing parameters
package uart_pkg;
    localparam int DEF_CLKS_PER_BIT = 10;
    localparam int DEF_NUM_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL = 1'b1;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP,
        DONE
    } tx_state_t;
endpackage

// File: rtl/flex_pts_sr.sv
// flex_pts_sr: parallel-to-serial shift register with parallel load, refilling with idle-high bits
module flex_pts_sr #(
    parameter int NUM_BITS = 8,
    parameter int SHIFT_MSB = 0
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load_enable,
    input  logic                shift_enable,
    input  logic [NUM_BITS-1:0] parallel_in,
    output logic                serial_out
);
    logic [NUM_BITS-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = load_enable ? parallel_in
             : !shift_enable ? sr_q
             : (SHIFT_MSB != 0) ? {sr_q[NUM_BITS-2:0], 1'b1}
             : {1'b1, sr_q[NUM_BITS-1:1]};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) sr_q <= '1;
        else sr_q <= sr_d;
    end

    assign serial_out = (SHIFT_MSB != 0) ? sr_q[NUM_BITS-1] : sr_q[0];
endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmitter (start, LSB-first data, stop); UART_TX_PARITY_EN adds an even-parity bit
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int NUM_BITS = DEF_NUM_BITS
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                tx_start,
    input  logic [NUM_BITS-1:0] tx_data,
    output logic                serial_out,
    output logic                tx_busy,
    output logic                tx_done
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = NUM_BITS > 1 ? $clog2(NUM_BITS) : 1;

    tx_state_t state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic serial_out_q, serial_out_d;
    logic tx_busy_q, tx_busy_d;
    logic tx_done_q, tx_done_d;
    logic strobe, last_bit, load, shift, sr_out;

    assign strobe = clk_cnt_q == CW'(CLKS_PER_BIT - 1);
    assign last_bit = bit_cnt_q == BW'(NUM_BITS - 1);
    assign load = (state_q == IDLE) && tx_start;
    assign shift = (state_q == DATA) && strobe;

    flex_pts_sr #(.NUM_BITS(NUM_BITS), .SHIFT_MSB(0)) u_sr (
        .clk(clk),
        .n_rst(n_rst),
        .load_enable(load),
        .shift_enable(shift),
        .parallel_in(tx_data),
        .serial_out(sr_out)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_q, parity_d;
    assign parity_d = load ? ^tx_data : parity_q;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) parity_q <= 1'b0;
        else parity_q <= parity_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = tx_start ? START : IDLE;
            START:   state_d = strobe ? DATA : START;
`ifdef UART_TX_PARITY_EN
            DATA:    state_d = (strobe && last_bit) ? PARITY : DATA;
            PARITY:  state_d = strobe ? STOP : PARITY;
`else
            DATA:    state_d = (strobe && last_bit) ? STOP : DATA;
`endif
            STOP:    state_d = strobe ? DONE : STOP;
            default: state_d = IDLE;
        endcase
        // restarting on every state change keeps each bit period exact
        clk_cnt_d = (state_q == IDLE || state_d != state_q || strobe) ? '0 : clk_cnt_q + 1'b1;
        bit_cnt_d = (state_q == DATA && state_d == DATA) ? bit_cnt_q + BW'(strobe) : '0;
        // outputs follow the registered state, so the line lags the state by one clock
`ifdef UART_TX_PARITY_EN
        serial_out_d = state_q == START ? START_LEVEL
                     : state_q == DATA ? sr_out
                     : state_q == PARITY ? parity_q
                     : state_q == STOP ? STOP_LEVEL : IDLE_LEVEL;
`else
        serial_out_d = state_q == START ? START_LEVEL
                     : state_q == DATA ? sr_out
                     : state_q == STOP ? STOP_LEVEL : IDLE_LEVEL;
`endif
        tx_busy_d = (state_q != IDLE) && (state_q != DONE);
        tx_done_d = state_q == DONE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            serial_out_q <= IDLE_LEVEL;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            serial_out_q <= serial_out_d;
            tx_busy_q <= tx_busy_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign serial_out = serial_out_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;
endmodule
